// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : WIDTH-bit add/subtract computed one nibble per cycle through a
//            single shared 4-bit ripple-carry stage.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int c_steps = WIDTH / 4;
    localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam int c_msb   = WIDTH - 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;

    logic [c_cnt_w+1:0] w_idx;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_sum;
    logic [4:0]         w_c;

    assign w_idx   = {r_cnt, 2'b00};
    assign w_a_nib = r_a[w_idx +: 4];
    assign w_b_nib = r_b[w_idx +: 4];
    assign w_c[0]  = r_carry;

    // The only adder in the design: one 4-bit ripple chain reused every step.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign w_sum[i]  = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
        assign w_c[i+1]  = (w_a_nib[i] & w_b_nib[i]) |
                           (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_result[w_idx +: 4] <= w_sum;
                    r_carry              <= w_c[4];
                    r_cnt                <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_carry_out <= w_c[4];
                        // w_sum[3] is the result MSB on the final step.
                        r_overflow  <= (r_a[c_msb] == r_b[c_msb]) &&
                                       (w_sum[3] != r_a[c_msb]);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Directed self-checking bench for nibble_serial_adder_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;

    int n_checks;
    int n_fail;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits on a negedge; returns on the negedge of the done cycle.
    // lat = cycles from start to done, or -1 if done never came.
    task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb,
                                  input logic tsub, output int lat);
        a = ta; b = tb; sub = tsub; start = 1'b1;
        lat = -1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", result); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", carry_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL basic_busy_cycle%0d got busy=%b done=%b exp busy=1 done=0", c, busy, done);
            end
            @(negedge clk);
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_cycle5 got done=%b busy=%b exp done=1 busy=0", done, busy); end
        n_checks++; if (result !== 16'h2233) begin n_fail++; $display("FAIL basic_result got=%h exp=2233", result); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b exp=0", carry_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        repeat (3) @(negedge clk);
        n_checks++; if (result !== 16'h2233 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_hold got result=%h busy=%b exp result=2233 busy=0", result, busy); end
    endtask

    task automatic test_add_edges();
        int lat;
        start_and_wait(16'hFFFF, 16'h0001, 1'b0, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL carry_latency got=%0d exp=5", lat); end
        n_checks++; if (result !== 16'h0000 || carry_out !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL carry_case got r=%h c=%b v=%b exp r=0000 c=1 v=0", result, carry_out, overflow); end
        @(negedge clk);
        start_and_wait(16'h7FFF, 16'h0001, 1'b0, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=5", lat); end
        n_checks++; if (result !== 16'h8000 || carry_out !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_case got r=%h c=%b v=%b exp r=8000 c=0 v=1", result, carry_out, overflow); end
        @(negedge clk);
    endtask

    task automatic test_sub();
        int lat;
        start_and_wait(16'h0005, 16'h0007, 1'b1, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sub1_latency got=%0d exp=5", lat); end
        n_checks++; if (result !== 16'hFFFE || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL sub1_case got r=%h c=%b v=%b exp r=FFFE c=0 v=0", result, carry_out, overflow); end
        @(negedge clk);
        start_and_wait(16'h8000, 16'h0001, 1'b1, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sub2_latency got=%0d exp=5", lat); end
        n_checks++; if (result !== 16'h7FFF || carry_out !== 1'b1 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL sub2_case got r=%h c=%b v=%b exp r=7FFF c=1 v=1", result, carry_out, overflow); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        @(negedge clk);                       // cycle 2: start while busy
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);                       // cycle 3
        start = 1'b0;
        @(negedge clk);                       // cycle 4
        @(negedge clk);                       // cycle 5
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got=%b exp=1", done); end
        n_checks++; if (result !== 16'h3333 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ignore_result got r=%h c=%b v=%b exp r=3333 c=0 v=0", result, carry_out, overflow); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued got done=%b busy=%b exp 0 0", done, busy); end
        // Now start exactly in a DONE cycle.
        start_and_wait(16'h0100, 16'h0200, 1'b0, lat);
        start_and_wait(16'h0A0B, 16'h0102, 1'b0, lat);
        // That call began in the DONE cycle of the 0100+0200 op.
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        n_checks++; if (result !== 16'h0B0D) begin n_fail++; $display("FAIL b2b_result got=%h exp=0B0D", result); end
        // Explicit busy check on the cycle after a DONE-cycle start.
        a = 16'h4000; b = 16'h4000; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got busy=%b done=%b exp 1 0", busy, done); end
        repeat (4) @(negedge clk);
        n_checks++; if (done !== 1'b1 || result !== 16'h8000 || carry_out !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL b2b_third got d=%b r=%h c=%b v=%b exp d=1 r=8000 c=0 v=1", done, result, carry_out, overflow); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        int n_done;
        a = 16'hAAAA; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        @(negedge clk);                       // cycle 2
        @(negedge clk);                       // cycle 3
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done); end
        n_checks++; if (result !== 16'h0000 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL midrst_data got r=%h c=%b v=%b exp 0 0 0", result, carry_out, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0 active cycles", n_done); end
        start_and_wait(16'h0001, 16'h0001, 1'b0, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL postrst_latency got=%0d exp=5", lat); end
        n_checks++; if (result !== 16'h0002 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL postrst_result got r=%h c=%b v=%b exp r=0002 c=0 v=0", result, carry_out, overflow); end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add_basic();
        test_add_edges();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
